// File: rtl/cache_arbiter_pkg.sv
// Shared types for the split I/D cache to physical-memory arbiter.
package cache_arbiter_pkg;

  localparam int unsigned S_LINE_DEFAULT = 256;
  localparam int unsigned S_ADDR_DEFAULT = 32;

  typedef logic [31:0] rv32i_word;

  // Arbiter FSM states: waiting for a request, or owning pmem for one cache.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  // Which cache was granted most recently; used to break ties.
  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } arb_port_t;

  // Round-robin choice between the two caches.
  // A lone requester always wins; on a tie the port that was not served last wins.
  function automatic arb_port_t pick_port(input logic i_req,
                                          input logic d_req,
                                          input arb_port_t last_grant);
    arb_port_t winner;
    if (i_req && d_req) begin
      winner = (last_grant == PORT_I) ? PORT_D : PORT_I;
    end else if (d_req) begin
      winner = PORT_D;
    end else begin
      winner = PORT_I;
    end
    return winner;
  endfunction

endpackage

// File: rtl/cache_arbiter_control.sv
// Arbitration FSM: picks which cache owns pmem and holds that grant until
// pmem completes. Grant selects are registered alongside the state.
module cache_arbiter_control
  import cache_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic d_req,
  input  logic pmem_resp,
  output logic grant_i,
  output logic grant_d
);

  arb_state_t state_q, state_d;
  arb_port_t  last_grant_q, last_grant_d;
  logic       grant_i_q, grant_i_d;
  logic       grant_d_q, grant_d_d;

  // Next-state logic: grant is decided only in IDLE and released only on pmem_resp.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d = (pick_port(i_req, d_req, last_grant_q) == PORT_D) ? SERVE_D : SERVE_I;
        end
      end
      SERVE_I: begin
        if (pmem_resp) begin
          state_d      = IDLE;
          last_grant_d = PORT_I;
        end
      end
      SERVE_D: begin
        if (pmem_resp) begin
          state_d      = IDLE;
          last_grant_d = PORT_D;
        end
      end
      default: state_d = IDLE;
    endcase
    grant_i_d = (state_d == SERVE_I);
    grant_d_d = (state_d == SERVE_D);
  end

  // State, round-robin history and grant flops; last_grant resets to I so D wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_I;
      grant_i_q    <= 1'b0;
      grant_d_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_i_q    <= grant_i_d;
      grant_d_q    <= grant_d_d;
    end
  end

  assign grant_i = grant_i_q;
  assign grant_d = grant_d_q;

endmodule

// File: rtl/cache_arbiter.sv
// Shares one physical-memory port between the I-cache and D-cache, one line
// transaction at a time, with round-robin tie-breaking.
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int unsigned s_line = S_LINE_DEFAULT,
  parameter int unsigned s_addr = S_ADDR_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic              i_pmem_write,
  input  logic [s_addr-1:0] i_pmem_address,
  input  logic [s_line-1:0] i_pmem_wdata,
  output logic              i_pmem_resp,
  output logic [s_line-1:0] i_pmem_rdata,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [s_addr-1:0] d_pmem_address,
  input  logic [s_line-1:0] d_pmem_wdata,
  output logic              d_pmem_resp,
  output logic [s_line-1:0] d_pmem_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [s_addr-1:0] pmem_address,
  output logic [s_line-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [s_line-1:0] pmem_rdata
);

  logic i_req;
  logic d_req;
  logic grant_i;
  logic grant_d;

  assign i_req = i_pmem_read | i_pmem_write;
  assign d_req = d_pmem_read | d_pmem_write;

  cache_arbiter_control u_control (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .d_req     (d_req),
    .pmem_resp (pmem_resp),
    .grant_i   (grant_i),
    .grant_d   (grant_d)
  );

  // Route the granted cache to pmem and gate resp back to it; idle drives zeros.
  // If a cache illegally raises read and write together, the write wins.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    if (grant_i) begin
      pmem_write   = i_pmem_write;
      pmem_read    = i_pmem_read & ~i_pmem_write;
      pmem_address = i_pmem_address;
      pmem_wdata   = i_pmem_wdata;
      i_pmem_resp  = pmem_resp;
    end else if (grant_d) begin
      pmem_write   = d_pmem_write;
      pmem_read    = d_pmem_read & ~d_pmem_write;
      pmem_address = d_pmem_address;
      pmem_wdata   = d_pmem_wdata;
      d_pmem_resp  = pmem_resp;
    end
  end

  // Read data is broadcast; only resp tells a cache the line is meant for it.
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

  // A granted cache must keep its request up until it sees resp.
  a_i_holds_request : assert property (@(posedge clk) disable iff (rst) grant_i |-> i_req);
  a_d_holds_request : assert property (@(posedge clk) disable iff (rst) grant_d |-> d_req);

  // Read and write together on one port is illegal.
  a_i_not_rw : assert property (@(posedge clk) disable iff (rst) !(i_pmem_read && i_pmem_write));
  a_d_not_rw : assert property (@(posedge clk) disable iff (rst) !(d_pmem_read && d_pmem_write));

endmodule
